// File: rtl/muxkey_reg_bank_pkg.sv
// Shared defaults for the NPC decode-stage register bank.
// Top-level parameters pick these up unless overridden.
package muxkey_reg_bank_pkg;

   localparam int XLEN_DEF    = 64;
   localparam int REG_SEL_DEF = 5;
   localparam int NR_REG_DEF  = 2 ** REG_SEL_DEF;

   localparam logic [XLEN_DEF-1:0] RESET_VAL_DEF = '0;

endpackage

// File: rtl/muxkey_reg_bank_if.sv
// Write/read/debug bundle of the register bank; the master drives addresses and data.
// Purely wires, no timing of its own.
interface muxkey_reg_bank_if
   import muxkey_reg_bank_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int NR_REG  = NR_REG_DEF,
   parameter int REG_SEL = REG_SEL_DEF
);

   logic                     wen;
   logic [REG_SEL-1:0]       waddr;
   logic [XLEN-1:0]          wdata;
   logic [REG_SEL-1:0]       raddr1;
   logic [REG_SEL-1:0]       raddr2;
   logic [XLEN-1:0]          rdata1;
   logic [XLEN-1:0]          rdata2;
   logic [NR_REG-1:0]        wen_onehot;
   logic [NR_REG*XLEN-1:0]   regs_flat;

   modport master (
      output wen, waddr, wdata, raddr1, raddr2,
      input  rdata1, rdata2, wen_onehot, regs_flat
   );

   modport slave (
      input  wen, waddr, wdata, raddr1, raddr2,
      output rdata1, rdata2, wen_onehot, regs_flat
   );

endinterface

// File: rtl/muxkey_reg_bank_key_mux.sv
// Generic keyed lookup: returns the data of the first {key,data} pair matching key, else 0.
// Zero latency, combinational; no flow control.
module key_mux #(
   parameter int NR_KEY   = 2,
   parameter int KEY_LEN  = 1,
   parameter int DATA_LEN = 1
) (
   output logic [DATA_LEN-1:0]                  out,
   input  logic [KEY_LEN-1:0]                   key,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

   localparam int PAIR_W = KEY_LEN + DATA_LEN;

   // Scan from the last pair up so pair 0 (MSB-most) overrides any later match.
   always_comb begin
      out = '0;
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         if (lut[(NR_KEY - i) * PAIR_W - 1 -: KEY_LEN] == key) begin
            out = lut[(NR_KEY - i) * PAIR_W - KEY_LEN - 1 -: DATA_LEN];
         end
      end
   end

endmodule

// File: rtl/muxkey_reg_bank.sv
// Register bank with one write port, two combinational read ports and x0 hard-wired to zero.
// Writes land on the next rising clk edge; reads are zero latency with no bypass; never stalls.
module muxkey_reg_bank
   import muxkey_reg_bank_pkg::*;
#(
   parameter int              XLEN      = XLEN_DEF,
   parameter int              NR_REG    = NR_REG_DEF,
   parameter int              REG_SEL   = REG_SEL_DEF,
   parameter logic [XLEN-1:0] RESET_VAL = XLEN'(RESET_VAL_DEF)
) (
   input  logic               clk,
   input  logic               rst,
   muxkey_reg_bank_if.slave   bus
);

   localparam int PAIR_W = REG_SEL + NR_REG;

   logic [NR_REG*PAIR_W-1:0] lut;
   logic [NR_REG-1:0]        onehot;
   logic [NR_REG-1:0]        wen_onehot;
   logic [NR_REG*XLEN-1:0]   regs_flat;

   // Key 0 maps to an empty enable, which is what keeps x0 at its reset value.
   for (genvar k = 0; k < NR_REG; k++) begin : g_lut
      localparam logic [REG_SEL-1:0] KEY = REG_SEL'(k);
      localparam logic [NR_REG-1:0]  DAT = (k == 0) ? '0 : (NR_REG'(1) << k);
      assign lut[(NR_REG - k) * PAIR_W - 1 -: PAIR_W] = {KEY, DAT};
   end

   key_mux #(
      .NR_KEY   (NR_REG),
      .KEY_LEN  (REG_SEL),
      .DATA_LEN (NR_REG)
   ) u_dec (
      .out (onehot),
      .key (bus.waddr),
      .lut (lut)
   );

   assign wen_onehot = bus.wen ? onehot : '0;

   for (genvar i = 0; i < NR_REG; i++) begin : g_reg
      logic [XLEN-1:0] q;

      always_ff @(posedge clk) begin
         if (rst) begin
            q <= RESET_VAL;
         end else if (wen_onehot[i]) begin
            q <= bus.wdata;
         end
      end

      assign regs_flat[i * XLEN +: XLEN] = q;
   end

   assign bus.rdata1     = regs_flat[bus.raddr1 * XLEN +: XLEN];
   assign bus.rdata2     = regs_flat[bus.raddr2 * XLEN +: XLEN];
   assign bus.wen_onehot = wen_onehot;
   assign bus.regs_flat  = regs_flat;

endmodule

// File: tb/tb_muxkey_reg_bank.sv
// Directed bench for muxkey_reg_bank plus a standalone key_mux lookup.
module tb_muxkey_reg_bank;

   logic clk = 1'b0;
   logic rst;

   muxkey_reg_bank_if bus ();

   muxkey_reg_bank u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [7:0]  km_out;
   logic [3:0]  km_key;
   logic [35:0] km_lut;

   key_mux #(
      .NR_KEY   (3),
      .KEY_LEN  (4),
      .DATA_LEN (8)
   ) u_km (
      .out (km_out),
      .key (km_key),
      .lut (km_lut)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   typedef struct {
      logic        wen;
      logic [4:0]  waddr;
      logic [63:0] wdata;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] exp_oh;
      logic [63:0] exp_rd1;
      logic [63:0] exp_rd2;
   } vec_t;

   vec_t        vecs [9];
   logic [63:0] model [32];

   task automatic check_all_words(input string tag);
      for (int k = 0; k < 32; k++) begin
         chk($sformatf("%s_w%0d", tag, k), bus.regs_flat[k*64 +: 64], model[k]);
      end
   endtask

   initial begin
      // Reads sampled before each edge: written data appears one vector later.
      vecs[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 5'd5,  5'd0,  32'h0000_0020, 64'h0, 64'h0};
      vecs[1] = '{1'b0, 5'd5,  64'h0,                   5'd5,  5'd5,  32'h0,         64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
      vecs[2] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  5'd5,  32'h0,         64'h0, 64'hDEAD_BEEF_0123_4567};
      vecs[3] = '{1'b0, 5'd0,  64'h0,                   5'd0,  5'd5,  32'h0,         64'h0, 64'hDEAD_BEEF_0123_4567};
      vecs[4] = '{1'b1, 5'd31, 64'h1,                   5'd31, 5'd30, 32'h8000_0000, 64'h0, 64'h0};
      vecs[5] = '{1'b1, 5'd30, 64'h2,                   5'd31, 5'd30, 32'h4000_0000, 64'h1, 64'h0};
      vecs[6] = '{1'b0, 5'd30, 64'h77,                  5'd31, 5'd30, 32'h0,         64'h1, 64'h2};
      vecs[7] = '{1'b1, 5'd5,  64'h1234,                5'd5,  5'd31, 32'h0000_0020, 64'hDEAD_BEEF_0123_4567, 64'h1};
      vecs[8] = '{1'b0, 5'd1,  64'h0,                   5'd5,  5'd1,  32'h0,         64'h1234, 64'h0};

      rst        = 1'b1;
      bus.wen    = 1'b0;
      bus.waddr  = '0;
      bus.wdata  = '0;
      bus.raddr1 = '0;
      bus.raddr2 = '0;
      km_key     = '0;
      km_lut     = {4'd3, 8'hAA, 4'd5, 8'hBB, 4'd3, 8'hCC};
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int k = 0; k < 32; k++) model[k] = 64'h0;
      check_all_words("reset0");
      chk("reset0_onehot", {32'h0, bus.wen_onehot}, 64'h0);

      for (int v = 0; v < 9; v++) begin
         bus.wen    = vecs[v].wen;
         bus.waddr  = vecs[v].waddr;
         bus.wdata  = vecs[v].wdata;
         bus.raddr1 = vecs[v].r1;
         bus.raddr2 = vecs[v].r2;
         #1;
         chk($sformatf("vec%0d_onehot", v), {32'h0, bus.wen_onehot}, {32'h0, vecs[v].exp_oh});
         chk($sformatf("vec%0d_rd1", v), bus.rdata1, vecs[v].exp_rd1);
         chk($sformatf("vec%0d_rd2", v), bus.rdata2, vecs[v].exp_rd2);
         @(posedge clk);
         #1;
      end
      model[5]  = 64'h1234;
      model[30] = 64'h2;
      model[31] = 64'h1;
      check_all_words("after_table");

      // wen=0 sweep: no enable bit and nothing changes.
      bus.wen = 1'b0;
      for (int k = 1; k < 32; k++) begin
         bus.waddr = 5'(k);
         bus.wdata = 64'hBAD0 + 64'(k);
         #1;
         chk($sformatf("sweep_off_oh%0d", k), {32'h0, bus.wen_onehot}, 64'h0);
         @(posedge clk);
         #1;
      end
      check_all_words("sweep_off");

      bus.wen = 1'b1;
      for (int k = 1; k < 32; k++) begin
         bus.waddr = 5'(k);
         bus.wdata = {32'hA5A5_0000, 32'(k)};
         #1;
         chk($sformatf("sweep_on_oh%0d", k), {32'h0, bus.wen_onehot}, 64'h1 << k);
         @(posedge clk);
         #1;
         model[k] = {32'hA5A5_0000, 32'(k)};
      end
      bus.wen = 1'b0;
      check_all_words("sweep_on");

      // Reset and a write to reg 7 on the same edge: reset wins.
      rst       = 1'b1;
      bus.wen   = 1'b1;
      bus.waddr = 5'd7;
      bus.wdata = 64'h55;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      bus.wen = 1'b0;
      for (int k = 0; k < 32; k++) model[k] = 64'h0;
      check_all_words("reset1");
      chk("rst_prio_r7", bus.regs_flat[7*64 +: 64], 64'h0);
      for (int k = 0; k < 32; k++) begin
         bus.raddr1 = 5'(k);
         bus.raddr2 = 5'(31 - k);
         #1;
         chk($sformatf("reset1_rd1_%0d", k), bus.rdata1, 64'h0);
         chk($sformatf("reset1_rd2_%0d", k), bus.rdata2, 64'h0);
      end

      // Standalone lookup: duplicate key 3 resolves to pair 0, absent keys give 0.
      km_key = 4'd3;
      #1;
      chk("km_key3_first", {56'h0, km_out}, 64'hAA);
      km_key = 4'd5;
      #1;
      chk("km_key5", {56'h0, km_out}, 64'hBB);
      km_key = 4'd9;
      #1;
      chk("km_absent9", {56'h0, km_out}, 64'h0);
      km_key = 4'd0;
      #1;
      chk("km_absent0", {56'h0, km_out}, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/muxkey_reg_bank.md
Name: muxkey_reg_bank

Overview:
- General-purpose register bank for the NPC decode stage: NR_REG registers of XLEN bits each, with one write port and two combinational read ports.
- The write address is decoded to a one-hot per-register write-enable vector by a generic keyed-lookup multiplexer (key → data table).
- Register 0 is hard-wired: the decoder maps key 0 to an all-zero enable, so x0 is never written.
- A flat debug view of all registers is exported for the simulation DPI hook.

Parameters:
- XLEN, 64, register data width.
- NR_REG, 32, number of registers; must equal 2**REG_SEL.
- REG_SEL, 5, register address width.
- RESET_VAL, 0, value every register takes on reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wen  in  1  global write enable.
- waddr  in  REG_SEL  destination register index.
- wdata  in  XLEN  write data.
- raddr1  in  REG_SEL  read port 1 index.
- raddr2  in  REG_SEL  read port 2 index.
- rdata1  out  XLEN  combinational read of register raddr1.
- rdata2  out  XLEN  combinational read of register raddr2.
- wen_onehot  out  NR_REG  decoded per-register enable; already gated by wen.
- regs_flat  out  NR_REG*XLEN  all registers concatenated, register i at bits [i*XLEN +: XLEN].

Behaviour:
- Register cell (per index i), evaluated on the rising edge of clk:
  - if rst, q <= RESET_VAL;
  - else if en_i, q <= wdata;
  - else q holds its value.
  - Reset has priority over write.
- Write decode:
  - en_i = wen AND onehot[i].
  - onehot comes from the keyed mux with the lookup table {0→0, k→(1<<k) for k = 1..NR_REG-1}.
  - Therefore reg 0 always reads RESET_VAL (0), and writes to index 0 are silently dropped.
- Keyed mux semantics:
  - Inputs: key (KEY_LEN bits) and a packed table of NR_KEY {key, data} pairs; pair 0 occupies the most-significant bits.
  - Output is the data of the matching pair. If several pairs match, the lowest-numbered pair (MSB-most) wins.
  - If no pair matches, the output is all zeros.
  - Purely combinational, zero latency.
- Reads:
  - Combinational, zero latency.
  - Reading the register written in the same cycle returns the old value until the clock edge (no write-to-read bypass).
  - Reading index 0 returns 0.
- Latency: a write is visible on rdata/regs_flat the cycle after the edge it is captured on.
- Reset mid-operation: if rst is asserted while wen=1, the write is discarded and all registers take RESET_VAL.
- wen_onehot is combinational, has at most one bit set, and bit 0 is always 0.
- Nothing is initialised outside reset; before the first reset, contents are X in simulation.

Decomposition:
- Shared package: XLEN, NR_REG, REG_SEL, RESET_VAL defaults.
- Sub-module key_mux, parameterized by NR_KEY, KEY_LEN, DATA_LEN (ports out, key, lut). It is reused elsewhere for generic lookups.
- The register cell is a generate-loop of NR_REG instances of a small enabled register; it does not need a separate package entry.

Test Plan:
- Reset: assert rst for 1 cycle after random writes → all regs_flat words = 0, rdata1/rdata2 = 0 for every index.
- Basic write/read: wen=1, waddr=5, wdata=64'hDEAD_BEEF_0123_4567, one edge → rdata1 (raddr1=5) equals that value; in the same cycle before the edge it still reads 0.
- x0 immutability: wen=1, waddr=0, wdata=64'hFFFF_FFFF_FFFF_FFFF → wen_onehot=32'h0; reg 0 stays 0.
- Decoder sweep: waddr=1..31 with wen=1 → wen_onehot = 1<<waddr; with wen=0 → wen_onehot=0 and no register changes.
- Reset priority: rst=1 and wen=1 with waddr=7, wdata=64'h55 on the same edge → reg 7 = 0.
- Dual read / key_mux default: write reg 31 = 64'h1 and reg 30 = 64'h2, read both ports simultaneously → 1 and 2. Standalone key_mux with a key absent from the table → out = 0.
